x_pattern_gen: RTL
==================

// Module: x_pattern_gen
// PURPOSE
//  Programmable stimulus sequencer that drives the serial input x of fsm_top (upstream stage).
//  Holds a table of up to NSEG (level, length) segments and plays them out cycle-accurately on x.
//  Replaces hand-timed bench stimulus with a synthesizable, repeatable source for on-board FSM checks.
// PARAMETERS
//  AW      3   segment index width; NSEG = 1<<AW table entries
//  LEN_W   8   segment length width, in clock cycles
//  IDLE_X  0   level driven on x when not running (reset, completion, abort)
// PORTS
//  clock     in   1      system clock, all logic on rising edge
//  reset     in   1      asynchronous, active-high reset
//  wr_en     in   1      table write strobe (honoured only when busy=0)
//  wr_addr   in   AW     table entry to write
//  wr_level  in   1      x level for the entry
//  wr_len    in   LEN_W  entry duration in cycles; 0 = end-of-sequence marker
//  start     in   1      begin playback from entry 0 (ignored when busy=1)
//  loop      in   1      sampled with start; 1 = repeat sequence until abort
//  abort     in   1      stop playback; highest priority after reset
//  x         out  1      stimulus to fsm_top.x
//  busy      out  1      1 while a sequence is playing
//  done      out  1      one-cycle pulse on normal (non-loop) completion
//  seg_idx   out  AW     index of entry currently driving x
// BEHAVIOUR
//  Reset (async, immediate): x=IDLE_X, busy=0, done=0, seg_idx=0, state IDLE, all table len=0, level=0.
//  States: IDLE, RUN. Registered cnt (LEN_W) counts remaining cycles of the current segment.
//  Table write: at edge with wr_en=1 and busy=0; ignored while busy. Start in the same cycle as a
//   write reads the pre-write table contents.
//  IDLE + start, tbl[0].len!=0: at that edge x<=tbl[0].level, cnt<=tbl[0].len-1, seg_idx<=0,
//   busy<=1, loop_q<=loop, go RUN. Latency: x changes in the cycle right after start is sampled.
//  IDLE + start, tbl[0].len==0: done=1 for one cycle, busy stays 0, x stays IDLE_X.
//  RUN, cnt!=0: cnt<=cnt-1, x held. Each segment drives its level for exactly len cycles.
//  RUN, cnt==0: advance. End of sequence when seg_idx==NSEG-1 (no wrap into entry 0)
//   or tbl[seg_idx+1].len==0.
//   - not end: seg_idx<=seg_idx+1, x<=next level, cnt<=next len-1.
//   - end, loop_q=1: reload entry 0 exactly as on start; no done, busy stays 1, no gap cycle.
//   - end, loop_q=0: x<=IDLE_X, busy<=0, done<=1 (one cycle), seg_idx<=0, go IDLE.
//  abort=1 (any state): next edge x<=IDLE_X, busy<=0, seg_idx<=0, cnt<=0, IDLE; done NOT
//   asserted. abort+start together: abort wins, no playback.
//  start while busy=1: ignored, loop_q unchanged.
//  All outputs registered; no combinational path from inputs to outputs.
// STRUCTURE
//  Shared header x_pattern_defs.vh: state encodings (ST_IDLE, ST_RUN), default AW/LEN_W.
//  Sub-module x_seg_table: NSEG x (1+LEN_W) register file, one write port, two read ports
//   (entry 0 and seg_idx+1), async-reset-cleared. Sequencer FSM + counter live in x_pattern_gen.
// TESTING (10 ns clock; bench instantiates x_pattern_gen driving fsm_top.x)
//  1 Load {0:3},{1:4},{0:7},{1:10},{0:4}, entry5 len=0, loop=0, start -> x low 3, high 4,
//    low 7, high 10, low 4 cycles; busy=1 for 28 cycles; done pulse on cycle 29; x=IDLE_X.
//  2 Same table, loop=1, start; abort at cycle 40 -> pattern repeats with no gap cycle and no
//    done; at abort edge+1: x=0, busy=0, seg_idx=0, done stays 0.
//  3 Reset table (all len=0), start -> done=1 for exactly one cycle, busy never rises, x=0.
//  4 All 8 entries len=1, levels alternating 1,0,... -> x toggles every cycle for 8 cycles,
//    seg_idx 0..7, then done; no read past entry 7.
//  5 During test 1, write entry 2 and pulse start at cycle 10 -> table/playback unaffected; assert
//    reset mid-run between edges -> x=0, busy=0 immediately, later start gives done only.

Source files
------------

// File: rtl/x_pattern_gen_pkg.sv
// Shared definitions for the x stimulus sequencer: default table geometry
// and the sequencer state encoding.
package x_pattern_gen_pkg;

  localparam int AW_DEF    = 3;
  localparam int LEN_W_DEF = 8;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/x_pattern_gen_seg_table.sv
// Segment table: NSEG entries of (level, length) with one write port and two
// read ports (entry 0 for (re)starts, an arbitrary entry for the next segment).
module x_pattern_gen_seg_table
  import x_pattern_gen_pkg::*;
#(
  parameter int AW    = AW_DEF,
  parameter int LEN_W = LEN_W_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic             wr_level,
  input  logic [LEN_W-1:0] wr_len,
  input  logic [AW-1:0]    rd_addr,
  output logic             first_level,
  output logic [LEN_W-1:0] first_len,
  output logic             rd_level,
  output logic [LEN_W-1:0] rd_len
);

  localparam int NSEG = 1 << AW;

  logic             levels [NSEG];
  logic [LEN_W-1:0] lens   [NSEG];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NSEG; i++) begin
        levels[i] <= 1'b0;
        lens[i]   <= '0;
      end
    end else if (wr_en) begin
      levels[wr_addr] <= wr_level;
      lens[wr_addr]   <= wr_len;
    end
  end

  // Reads see the registered contents, so a same-cycle write is not visible yet.
  assign first_level = levels[0];
  assign first_len   = lens[0];
  assign rd_level    = levels[rd_addr];
  assign rd_len      = lens[rd_addr];

endmodule

// File: rtl/x_pattern_gen.sv
// Programmable stimulus sequencer: plays a table of (level, length) segments
// cycle-accurately on x, optionally looping until aborted.
module x_pattern_gen
  import x_pattern_gen_pkg::*;
#(
  parameter int   AW     = AW_DEF,
  parameter int   LEN_W  = LEN_W_DEF,
  parameter logic IDLE_X = 1'b0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic             wr_level,
  input  logic [LEN_W-1:0] wr_len,
  input  logic             start,
  input  logic             loop,
  input  logic             abort,
  output logic             x,
  output logic             busy,
  output logic             done,
  output logic [AW-1:0]    seg_idx
);

  localparam logic [AW-1:0]    LAST_IDX = AW'((1 << AW) - 1);
  localparam logic [AW-1:0]    IDX_ONE  = AW'(1);
  localparam logic [LEN_W-1:0] LEN_ONE  = LEN_W'(1);

  state_t           state;
  logic [LEN_W-1:0] cnt;
  logic             loop_q;
  logic [AW-1:0]    next_idx;
  logic             first_level;
  logic [LEN_W-1:0] first_len;
  logic             next_level;
  logic [LEN_W-1:0] next_len;
  logic             seq_end;

  assign next_idx = seg_idx + IDX_ONE;
  // The last entry never wraps into entry 0; a zero length also ends the sequence.
  assign seq_end  = (seg_idx == LAST_IDX) || (next_len == '0);

  x_pattern_gen_seg_table #(
    .AW    (AW),
    .LEN_W (LEN_W)
  ) u_table (
    .clock       (clock),
    .reset       (reset),
    .wr_en       (wr_en && !busy),
    .wr_addr     (wr_addr),
    .wr_level    (wr_level),
    .wr_len      (wr_len),
    .rd_addr     (next_idx),
    .first_level (first_level),
    .first_len   (first_len),
    .rd_level    (next_level),
    .rd_len      (next_len)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= ST_IDLE;
      x       <= IDLE_X;
      busy    <= 1'b0;
      done    <= 1'b0;
      seg_idx <= '0;
      cnt     <= '0;
      loop_q  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (abort) begin
        state   <= ST_IDLE;
        x       <= IDLE_X;
        busy    <= 1'b0;
        seg_idx <= '0;
        cnt     <= '0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (start) begin
              if (first_len != '0) begin
                state   <= ST_RUN;
                x       <= first_level;
                cnt     <= first_len - LEN_ONE;
                seg_idx <= '0;
                busy    <= 1'b1;
                loop_q  <= loop;
              end else begin
                done <= 1'b1;
              end
            end
          end
          ST_RUN: begin
            if (cnt != '0) begin
              cnt <= cnt - LEN_ONE;
            end else if (!seq_end) begin
              seg_idx <= next_idx;
              x       <= next_level;
              cnt     <= next_len - LEN_ONE;
            end else if (loop_q) begin
              seg_idx <= '0;
              x       <= first_level;
              cnt     <= first_len - LEN_ONE;
            end else begin
              state   <= ST_IDLE;
              x       <= IDLE_X;
              busy    <= 1'b0;
              done    <= 1'b1;
              seg_idx <= '0;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule
